// File: rtl/sp_instr_issuer.sv
// sp_instr_issuer
//
// Sits in front of the scratchpad instruction FIFO. It takes one matrix-level
// command per handshake (LOAD, STORE or GEMM) and expands it into FIFO
// entries. LOAD and STORE produce one entry per matrix row. GEMM produces a
// single entry. The block also caps the number of in-flight LOAD+GEMM
// commands, using the scratchpad's completion pulses to retire them.
//
// Ports
//   CLK, RST          clock (rising edge); asynchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_op            01 LOAD, 10 STORE, 11 GEMM, 00 illegal
//   cmd_mat           target/destination matrix
//   cmd_base          byte address of row 0 (LOAD/STORE)
//   cmd_srcs          GEMM sources {A,B}
//   instrFIFO_full    back-pressure from the instruction FIFO
//   instrFIFO_WEN     FIFO write strobe
//   instrFIFO_wdata   {op, mat, row, addr}
//   load_complete     one-cycle pulse: one LOAD retired
//   gemm_complete     one-cycle pulse: one GEMM retired
//   busy              expanding a command, or commands still in flight
//   outstanding       in-flight LOAD+GEMM count
//   err               sticky: illegal op or completion underflow
module sp_instr_issuer #(
  parameter int MAT_S_W    = 2,
  parameter int ROW_S_W    = 2,
  parameter int WORD_W     = 32,
  parameter int ROW_STRIDE = 8,
  parameter int MAX_OUT    = 4
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [1:0]                             cmd_op,
  input  logic [MAT_S_W-1:0]                     cmd_mat,
  input  logic [WORD_W-1:0]                      cmd_base,
  input  logic [2*MAT_S_W-1:0]                   cmd_srcs,
  input  logic                                   instrFIFO_full,
  output logic                                   instrFIFO_WEN,
  output logic [2+MAT_S_W+ROW_S_W+WORD_W-1:0]    instrFIFO_wdata,
  input  logic                                   load_complete,
  input  logic                                   gemm_complete,
  output logic                                   busy,
  output logic [3:0]                             outstanding,
  output logic                                   err
);

  localparam int                 NUM_ROWS  = 2 ** ROW_S_W;
  localparam logic [ROW_S_W-1:0] LAST_ROW  = ROW_S_W'(NUM_ROWS - 1);
  localparam logic [WORD_W-1:0]  STRIDE    = WORD_W'(ROW_STRIDE);
  localparam logic [3:0]         MAX_OUT_C = 4'(MAX_OUT);

  localparam logic [1:0] OP_ILL   = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_GEMM  = 2'b11;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [MAT_S_W-1:0]   mat_q, mat_d;
  logic [ROW_S_W-1:0]   row_q, row_d;
  logic [WORD_W-1:0]    addr_q, addr_d;
  logic [3:0]           out_q, out_d;
  logic                 err_q, err_d;

  logic                 write;
  logic                 last_entry;
  logic                 handshake;
  logic                 inc;
  logic [4:0]           sum;
  logic [4:0]           dec;

  // Ready looks only at the registered count, so a completion arriving in
  // the same cycle as a blocked handshake raises ready one cycle later.
  assign cmd_ready  = (state_q == S_IDLE) && (out_q < MAX_OUT_C);
  assign handshake  = cmd_valid && cmd_ready;
  assign write      = (state_q == S_ISSUE) && !instrFIFO_full;
  assign last_entry = (op_q == OP_GEMM) || (row_q == LAST_ROW);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mat_d   = mat_q;
    row_d   = row_q;
    addr_d  = addr_q;
    err_d   = err_q;
    inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          if (cmd_op == OP_ILL) begin
            // Consumed but never expanded.
            err_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            op_d    = cmd_op;
            mat_d   = cmd_mat;
            row_d   = '0;
            // GEMM carries its {A,B} sources in the address field.
            addr_d  = (cmd_op == OP_GEMM) ? WORD_W'(cmd_srcs) : cmd_base;
          end
        end
      end
      S_ISSUE: begin
        if (write) begin
          row_d  = row_q + ROW_S_W'(1);
          addr_d = addr_q + STRIDE;
          if (last_entry) begin
            state_d = S_IDLE;
            inc     = (op_q != OP_STORE);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Net in-flight change; a completion with nothing to retire clamps at
    // zero and flags the error.
    sum = {1'b0, out_q} + 5'(inc);
    dec = 5'(load_complete) + 5'(gemm_complete);
    if (sum < dec) begin
      out_d = '0;
      err_d = 1'b1;
    end else begin
      out_d = 4'(sum - dec);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      mat_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mat_q   <= mat_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign instrFIFO_WEN   = write;
  assign instrFIFO_wdata = {op_q, mat_q, row_q, addr_q};
  assign busy            = (state_q != S_IDLE) || (out_q != 4'd0);
  assign outstanding     = out_q;
  assign err             = err_q;

endmodule
